// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared sizes and FSM state encoding for the 4-way round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin search: first set req bit at or above ptr, mod 4.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      idx   = ptr;
      found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[ptr + IDX_W'(k)]) begin
            idx   = ptr + IDX_W'(k);
            found = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : 4-requester round-robin arbiter, registered one-hot grant with a
//            one-cycle gap between owners. Define ARB_TIMEOUT_EN to bound grants
//            to TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int TIMEOUT = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld,
   output logic             timeout
);

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
   logic             r_vld, w_vld_nxt;
   logic             r_to, w_to_nxt;
   logic [IDX_W-1:0] w_pick;
   logic             w_found;
   logic             w_force;
   logic             w_release;

   // Legal TIMEOUT is 1..255; nothing is built for an out-of-range value.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_bad
   end

   rr_pick u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .idx   (w_pick),
      .found (w_found)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == GRANT) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   assign w_force = (r_state == GRANT) && ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));
`else
   assign w_force = 1'b0;
`endif

   assign w_release = !req[r_idx] || w_force;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_gnt   <= '0;
         r_vld   <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_gnt   <= w_gnt_nxt;
         r_vld   <= w_vld_nxt;
         r_to    <= w_to_nxt;
      end
   end

   // The single GAP cycle also arbitrates (from the advanced ptr), so a waiting
   // requester sees exactly one idle grant cycle after a release.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_gnt_nxt   = r_gnt;
      w_vld_nxt   = r_vld;
      w_to_nxt    = 1'b0;
      case (r_state)
         IDLE, GAP: begin
            if (w_found) begin
               w_state_nxt = GRANT;
               w_idx_nxt   = w_pick;
               w_gnt_nxt   = NREQ'(1) << w_pick;
               w_vld_nxt   = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_state_nxt = GAP;
               w_gnt_nxt   = '0;
               w_vld_nxt   = 1'b0;
               w_ptr_nxt   = r_idx + IDX_W'(1);
               w_to_nxt    = w_force && req[r_idx];
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_vld_nxt   = 1'b0;
         end
      endcase
   end

   assign gnt     = r_gnt;
   assign gnt_idx = r_idx;
   assign gnt_vld = r_vld;
   assign timeout = r_to;

endmodule : rr_arbiter
`default_nettype wire
